// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the vector load/store unit FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } vlsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath <-> load/store unit <-> cache bundle. The single halt wire is driven by the
// datapath and read by the cache, so the cache-side halt always equals the datapath halt.
interface load_store_unit_if #(
    parameter int THREADS = 4,
    parameter int CPUS    = 2,
    parameter int CPUID   = 0
);
    import cpu_types_pkg::*;

    logic  instReq, readReq, writeReq, isVector, halt;
    word_t vdaddr  [THREADS];
    word_t vdstore [THREADS];
    word_t sdaddr, sdstore, iaddr;

    logic  iHit, dHit;
    word_t iload, sdload;
    word_t vdload [THREADS];

    word_t imemload, dmemload;
    logic  icacheHit, dcacheHit;
    logic  imemREN, dmemREN, dmemWEN;
    word_t imemaddr, dmemaddr, dmemstore;

    modport datapath (
        output instReq, readReq, writeReq, isVector, halt,
        output vdaddr, vdstore, sdaddr, sdstore, iaddr,
        input  iHit, dHit, iload, sdload, vdload
    );

    modport cache (
        input  imemREN, dmemREN, dmemWEN, imemaddr, dmemaddr, dmemstore, halt,
        output imemload, dmemload, icacheHit, dcacheHit
    );

    modport loadstore (
        input  instReq, readReq, writeReq, isVector, halt,
        input  vdaddr, vdstore, sdaddr, sdstore, iaddr,
        input  imemload, dmemload, icacheHit, dcacheHit,
        output iHit, dHit, iload, sdload, vdload,
        output imemREN, dmemREN, dmemWEN, imemaddr, dmemaddr, dmemstore
    );

endinterface

// File: rtl/vector_load_store_unit_lane_seq.sv
// Lane sequencer: lane counter, last-lane flag and (with VLSU_COALESCE_EN) the
// same-address-as-previous-lane compare used to skip redundant vector reads.
module vlsu_lane_seq
    import cpu_types_pkg::*;
#(
    parameter int THREADS = 4,
    localparam int LW     = $clog2(THREADS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clear,
    input  logic          advance,
`ifdef VLSU_COALESCE_EN
    input  word_t         vdaddr [THREADS],
    output logic [LW-1:0] prevLane,
    output logic          sameAddr,
`endif
    output logic [LW-1:0] lane,
    output logic          isLast
);
    localparam logic [LW-1:0] LANE_LAST = LW'(THREADS - 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (advance) begin
            lane <= lane + LW'(1);
        end
    end

    assign isLast = (lane == LANE_LAST);

`ifdef VLSU_COALESCE_EN
    assign prevLane = lane - LW'(1);
    assign sameAddr = (lane != '0) && (vdaddr[lane] == vdaddr[prevLane]);
`endif

endmodule

// File: rtl/vector_load_store_unit.sv
// Load/store unit: passes instruction fetches straight through and serializes vector
// data accesses into one cache word per lane. Optional read coalescing: VLSU_COALESCE_EN.
module vector_load_store_unit
    import cpu_types_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int CPUS    = 2,
    parameter int CPUID   = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    load_store_unit_if.loadstore  lsuif,
    output vlsu_state_t           dbgState
);
    localparam int LW = $clog2(THREADS);

    vlsu_state_t   state;
    logic          opWr, opVec;
    logic [LW-1:0] lane;
    logic          isLast, inAccess, coalesce, laneDone, advance;
    word_t         prevData;
    word_t         sdloadQ;
    word_t         vdloadQ [THREADS];

    assign lsuif.imemREN  = lsuif.instReq;
    assign lsuif.imemaddr = lsuif.iaddr;
    assign lsuif.iload    = lsuif.imemload;
    assign lsuif.iHit     = lsuif.instReq & lsuif.icacheHit;

`ifdef VLSU_COALESCE_EN
    logic [LW-1:0] prevLane;
    logic          sameAddr;

    vlsu_lane_seq #(.THREADS(THREADS)) u_laneSeq (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (state == IDLE),
        .advance  (advance),
        .vdaddr   (lsuif.vdaddr),
        .prevLane (prevLane),
        .sameAddr (sameAddr),
        .lane     (lane),
        .isLast   (isLast)
    );

    // A vector read lane repeating the previous lane's address reuses its data.
    assign coalesce = opVec & ~opWr & sameAddr;
    assign prevData = vdloadQ[prevLane];
`else
    vlsu_lane_seq #(.THREADS(THREADS)) u_laneSeq (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (state == IDLE),
        .advance (advance),
        .lane    (lane),
        .isLast  (isLast)
    );

    assign coalesce = 1'b0;
    assign prevData = '0;
`endif

    assign inAccess  = (state == ACCESS);
    assign laneDone  = lsuif.dcacheHit | coalesce;
    assign advance   = inAccess & ~lsuif.halt & laneDone & opVec & ~isLast;

    assign lsuif.dmemREN   = inAccess & ~lsuif.halt & ~opWr & ~coalesce;
    assign lsuif.dmemWEN   = inAccess & ~lsuif.halt & opWr;
    assign lsuif.dmemaddr  = opVec ? lsuif.vdaddr[lane]  : lsuif.sdaddr;
    assign lsuif.dmemstore = opVec ? lsuif.vdstore[lane] : lsuif.sdstore;
    assign lsuif.dHit      = (state == DONE);
    assign lsuif.sdload    = sdloadQ;
    assign dbgState        = state;

    for (genvar g = 0; g < THREADS; g++) begin : g_vdload
        assign lsuif.vdload[g] = vdloadQ[g];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            opWr    <= 1'b0;
            opVec   <= 1'b0;
            sdloadQ <= '0;
            for (int i = 0; i < THREADS; i++) begin
                vdloadQ[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (lsuif.readReq | lsuif.writeReq) begin
                        opWr  <= lsuif.writeReq;
                        opVec <= lsuif.isVector;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Halt abandons the operation; lanes already captured stay put.
                    if (lsuif.halt) begin
                        state <= IDLE;
                    end else if (laneDone) begin
                        if (!opWr) begin
                            if (opVec) begin
                                vdloadQ[lane] <= coalesce ? prevData : lsuif.dmemload;
                            end else begin
                                sdloadQ <= lsuif.dmemload;
                            end
                        end
                        if (!opVec || isLast) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Bench for vector_load_store_unit: directed table, reset/halt sequences and random ops
// against a memory-level reference model; the bench also plays the cache.
module tb_vector_load_store_unit;
  import cpu_types_pkg::*;

  localparam int T = 4;
`ifdef VLSU_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.THREADS(T)) lsuif ();
  vlsu_state_t dbg_state;

  vector_load_store_unit #(.THREADS(T), .CPUS(2), .CPUID(0)) dut (
    .CLK      (clk),
    .RST      (rst),
    .lsuif    (lsuif),
    .dbgState (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] st_q[$];
  int wt_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_sd;
  logic [31:0] exp_vd [T];
  logic [3:0][31:0] op_addr;
  logic [3:0][31:0] op_store;
  logic [3:0][3:0] op_wait;

  typedef struct {
    string name;
    logic rd;
    logic wr;
    logic vec;
    logic [3:0][31:0] addr;
    logic [3:0][31:0] store;
    logic [3:0][3:0] waits;
    int exp_hit;
    int exp_acc;
    logic chk_sd;
    logic [31:0] exp_sd;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input string name, input logic rd, input logic wr, input logic vec,
                              input logic [3:0][31:0] addr, input logic [3:0][31:0] store,
                              input logic [3:0][3:0] waits, input int exp_hit, input int exp_acc,
                              input logic chk_sd, input logic [31:0] esd);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.vec = vec;
    v.addr = addr; v.store = store; v.waits = waits;
    v.exp_hit = exp_hit; v.exp_acc = exp_acc; v.chk_sd = chk_sd; v.exp_sd = esd;
    return v;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_loads(input string tag);
    check({tag, " sdload"}, lsuif.sdload, exp_sd);
    for (int i = 0; i < T; i++) begin
      check($sformatf("%s vdload[%0d]", tag, i), lsuif.vdload[i], exp_vd[i]);
    end
  endtask

  // ---------------- driver: one data op with the bench acting as cache ----------------
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic vec,
                        input int exp_hit_in, input int exp_acc_in);
    int n, m_hit, m_acc, hit_cyc, hits, acc, wait_rem, e_hit, e_acc;
    logic coal;
    logic [31:0] a, prev_a;
    exp_q.delete(); st_q.delete(); wt_q.delete();
    n = vec ? T : 1;
    m_hit = 1; m_acc = 0; prev_a = '0;
    for (int l = 0; l < n; l++) begin
      a = op_addr[l];
      coal = COAL && vec && !wr && (l > 0) && (a == prev_a);
      if (coal) begin
        m_hit += 1;
      end else begin
        exp_q.push_back(a);
        st_q.push_back(op_store[l]);
        wt_q.push_back(int'(op_wait[l]));
        m_hit += 1 + int'(op_wait[l]);
        m_acc += 1 + int'(op_wait[l]);
      end
      if (!wr) begin
        if (vec) exp_vd[l] = mem_rd(a);
        else exp_sd = mem_rd(a);
      end
      prev_a = a;
    end
    e_hit = (exp_hit_in < 0) ? m_hit : exp_hit_in;
    e_acc = (exp_acc_in < 0) ? m_acc : exp_acc_in;

    @(negedge clk);
    lsuif.readReq = rd; lsuif.writeReq = wr; lsuif.isVector = vec;
    lsuif.sdaddr = op_addr[0]; lsuif.sdstore = op_store[0];
    for (int i = 0; i < T; i++) begin
      lsuif.vdaddr[i] = op_addr[i];
      lsuif.vdstore[i] = op_store[i];
    end
    hit_cyc = -1; hits = 0; acc = 0;
    wait_rem = (wt_q.size() > 0) ? wt_q[0] : 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      lsuif.dcacheHit = 1'b0;
      lsuif.dmemload = $urandom;
      if (lsuif.dHit) begin
        hits++;
        if (hit_cyc < 0) hit_cyc = c;
        lsuif.readReq = 1'b0; lsuif.writeReq = 1'b0;
      end
      if (lsuif.dmemREN || lsuif.dmemWEN) begin
        acc++;
        if (exp_q.size() > 0) begin
          check({tag, " dmemaddr"}, lsuif.dmemaddr, exp_q[0]);
          check({tag, " dmemWEN"}, lsuif.dmemWEN, wr);
          if (wr) check({tag, " dmemstore"}, lsuif.dmemstore, st_q[0]);
          if (wait_rem > 0) begin
            wait_rem--;
          end else begin
            lsuif.dcacheHit = 1'b1;
            if (wr) mem[exp_q[0]] = st_q[0];
            else lsuif.dmemload = mem_rd(exp_q[0]);
            void'(exp_q.pop_front()); void'(st_q.pop_front()); void'(wt_q.pop_front());
            wait_rem = (wt_q.size() > 0) ? wt_q[0] : 0;
          end
        end
      end
      if (hit_cyc >= 0 && c >= hit_cyc + 2) break;
    end
    lsuif.readReq = 1'b0; lsuif.writeReq = 1'b0; lsuif.dcacheHit = 1'b0;
    check({tag, " dHit cycle (ffffffff = never)"}, hit_cyc, e_hit);
    check({tag, " dHit pulses"}, hits, 1);
    check({tag, " access cycles"}, acc, e_acc);
    check({tag, " pending accesses"}, exp_q.size(), 0);
    check({tag, " end state"}, 32'(dbg_state), 32'(IDLE));
    check_loads(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int kind, hcount;
    logic ir, ih;
    logic [31:0] ia, il;

    tbl[0] = mk("scalar_rd", 1, 0, 0, {32'h0, 32'h0, 32'h0, 32'h100}, '0, '0, 2, 1, 1, 32'hDEAD_BEEF);
    tbl[1] = mk("vec_rd", 1, 0, 1, {32'hC, 32'h8, 32'h4, 32'h0}, '0, '0, 5, 4, 0, '0);
    tbl[2] = mk("vec_wr_wait", 0, 1, 1, {32'h4C, 32'h48, 32'h44, 32'h40},
                {32'hD3, 32'hC2, 32'hB1, 32'hA0}, {4'd0, 4'd2, 4'd0, 4'd0}, 7, 6, 0, '0);
    tbl[3] = mk("rd_and_wr", 1, 1, 0, {32'h0, 32'h0, 32'h0, 32'h100}, {96'h0, 32'h1234_5678},
                '0, 2, 1, 1, 32'hDEAD_BEEF);
    tbl[4] = mk("scalar_rd_wait", 1, 0, 0, {32'h0, 32'h0, 32'h0, 32'h100}, '0, {12'h0, 4'd3},
                5, 4, 1, 32'h1234_5678);
    tbl[5] = mk("vec_rd_dup", 1, 0, 1, {32'h24, 32'h24, 32'h20, 32'h20}, '0, '0, 5,
                COAL ? 2 : 4, 0, '0);
    tbl[6] = mk("vec_rd_back", 1, 0, 1, {32'h4C, 32'h48, 32'h44, 32'h40}, '0,
                {4'd0, 4'd1, 4'd0, 4'd1}, 7, 6, 0, '0);

    mem[32'h100] = 32'hDEAD_BEEF;
    exp_sd = '0;
    for (int i = 0; i < T; i++) exp_vd[i] = '0;

    lsuif.instReq = 0; lsuif.readReq = 0; lsuif.writeReq = 0; lsuif.isVector = 0; lsuif.halt = 0;
    lsuif.sdaddr = 0; lsuif.sdstore = 0; lsuif.iaddr = 0;
    lsuif.imemload = 0; lsuif.dmemload = 0; lsuif.icacheHit = 0; lsuif.dcacheHit = 0;
    for (int i = 0; i < T; i++) begin
      lsuif.vdaddr[i] = 0; lsuif.vdstore[i] = 0;
    end

    // reset state
    repeat (3) @(negedge clk);
    check("reset dHit", lsuif.dHit, 1'b0);
    check("reset dmemREN", lsuif.dmemREN, 1'b0);
    check("reset dmemWEN", lsuif.dmemWEN, 1'b0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    check_loads("reset");
    rst = 1'b0;

    // instruction path
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ir = 1'($urandom_range(0, 1)); ih = 1'($urandom_range(0, 1));
      ia = $urandom; il = $urandom;
      lsuif.instReq = ir; lsuif.icacheHit = ih; lsuif.iaddr = ia; lsuif.imemload = il;
      #1;
      check("iHit", lsuif.iHit, ir & ih);
      check("imemREN", lsuif.imemREN, ir);
      check("imemaddr", lsuif.imemaddr, ia);
      check("iload", lsuif.iload, il);
    end
    lsuif.instReq = 0; lsuif.icacheHit = 0;

    // directed table
    for (int i = 0; i < 7; i++) begin
      op_addr = tbl[i].addr; op_store = tbl[i].store; op_wait = tbl[i].waits;
      run_op(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].vec, tbl[i].exp_hit, tbl[i].exp_acc);
      if (tbl[i].chk_sd) check({tbl[i].name, " sdload value"}, lsuif.sdload, tbl[i].exp_sd);
    end

    // reset during lane 1 of a vector read
    @(negedge clk);
    lsuif.readReq = 1; lsuif.isVector = 1;
    for (int i = 0; i < T; i++) lsuif.vdaddr[i] = 32'h60 + 32'(4 * i);
    @(negedge clk);
    check("rst_seq lane0 addr", lsuif.dmemaddr, 32'h60);
    lsuif.dcacheHit = 1; lsuif.dmemload = mem_rd(32'h60);
    @(negedge clk);
    lsuif.dcacheHit = 0;
    check("rst_seq lane1 addr", lsuif.dmemaddr, 32'h64);
    check("rst_seq lane1 REN", lsuif.dmemREN, 1'b1);
    #2 rst = 1'b1;
    #1;
    lsuif.readReq = 0;
    for (int i = 0; i < T; i++) exp_vd[i] = '0;
    exp_sd = '0;
    check("rst_seq dmemREN", lsuif.dmemREN, 1'b0);
    check("rst_seq state", 32'(dbg_state), 32'(IDLE));
    check_loads("rst_seq");
    @(negedge clk);
    rst = 1'b0;
    hcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (lsuif.dHit) hcount++;
    end
    check("rst_seq dHit count", hcount, 0);

    // halt during ACCESS
    @(negedge clk);
    lsuif.readReq = 1; lsuif.isVector = 1;
    for (int i = 0; i < T; i++) lsuif.vdaddr[i] = 32'h70 + 32'(4 * i);
    @(negedge clk);
    lsuif.dcacheHit = 1; lsuif.dmemload = mem_rd(32'h70);
    exp_vd[0] = mem_rd(32'h70);
    @(negedge clk);
    lsuif.dcacheHit = 0; lsuif.halt = 1; lsuif.readReq = 0;
    #1;
    check("halt dmemREN", lsuif.dmemREN, 1'b0);
    check("halt dmemWEN", lsuif.dmemWEN, 1'b0);
    hcount = 0;
    repeat (4) begin
      @(negedge clk);
      lsuif.halt = 0;
      if (lsuif.dHit) hcount++;
    end
    check("halt dHit count", hcount, 0);
    check("halt state", 32'(dbg_state), 32'(IDLE));
    check_loads("halt");

    // random ops against the reference model
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      for (int l = 0; l < T; l++) begin
        op_addr[l] = 32'h20 + 32'(4 * $urandom_range(0, 3));
        op_store[l] = $urandom;
        op_wait[l] = 4'($urandom_range(0, 2));
      end
      run_op($sformatf("rand%0d", k), kind != 1, kind != 0, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_load_store_unit.md
# vector_load_store_unit

Responder side of `load_store_unit_if`. It accepts scalar and vector data requests plus instruction fetches from the datapath. Vector accesses are serialized into one single-word cache transaction per thread lane, and the load results are returned to the datapath. It sits between the SIMT datapath (`datapath` modport) and the cache hierarchy (`cache` modport), and is connected through the `loadstore` modport.

## Interface
Parameters:
- `THREADS`, default 4: number of vector lanes; must be ≥ 2.
- `CPUS`, default 2: passed through to the interface; unused in logic.
- `CPUID`, default 0: passed through to the interface; unused in logic.

Ports (all `word_t` signals are 32 bits; other ports are bundled in `load_store_unit_if.loadstore`):
- `CLK`, in, 1: the single clock.
- `RST`, in, 1: asynchronous, active-high reset.
- `instReq`, `readReq`, `writeReq`, `isVector`, in, 1 each: datapath request controls.
- `vdaddr[THREADS]`, `vdstore[THREADS]`, in, `word_t`: per-lane address and store data.
- `sdaddr`, `sdstore`, `iaddr`, in, `word_t`: scalar data address, scalar store data, instruction address.
- `halt`, in, 1: datapath halt, forwarded to the cache.
- `iHit`, `dHit`, out, 1: instruction done; data done (one-cycle pulse).
- `iload`, `sdload`, out, `word_t`; `vdload[THREADS]`, out, `word_t`: returned data.
- `imemload`, `dmemload`, in, `word_t`; `icacheHit`, `dcacheHit`, in, 1: cache responses.
- `imemREN`, `dmemREN`, `dmemWEN`, out, 1; `imemaddr`, `dmemaddr`, `dmemstore`, out, `word_t`: cache requests.
- `halt` (cache side), out, 1: equals the input `halt`.

## Operation
- Instruction path is combinational:
  - `imemREN = instReq`, `imemaddr = iaddr`, `iload = imemload`, `iHit = instReq & icacheHit`.
- Data FSM has three states: `IDLE`, `ACCESS`, `DONE`.
- `IDLE`:
  - `readReq | writeReq` accepts the request.
  - `op_wr` latches `writeReq`. If `readReq` and `writeReq` are both high, the access is a write.
  - `op_vec` latches `isVector`.
  - `lane` clears to 0. Next state is `ACCESS`.
- `ACCESS`:
  - `dmemREN = !op_wr`, `dmemWEN = op_wr`.
  - `dmemaddr = op_vec ? vdaddr[lane] : sdaddr`.
  - `dmemstore = op_vec ? vdstore[lane] : sdstore`.
  - On `dcacheHit`, a read captures `dmemload` into `vdload[lane]` (vector) or `sdload` (scalar); `lane` then increments.
  - Scalar access, or `lane == THREADS-1`, moves to `DONE` on hit. Otherwise the FSM stays in `ACCESS` with the next lane.
- `DONE`:
  - `dHit = 1` for exactly one cycle, then `IDLE`.
- The datapath holds addresses, store data and request lines stable from request until `dHit`, and drops the request in the cycle after `dHit`. These signals are not latched here.
- `halt` high in `ACCESS`:
  - `dmemREN` and `dmemWEN` drop combinationally.
  - Next state is `IDLE` with no `dHit`.
  - Captured data is kept.
- Reset (asynchronous, any state):
  - State goes to `IDLE`, `lane` to 0.
  - `sdload` and all `vdload[*]` go to 0; `op_wr` and `op_vec` go to 0.
  - `dHit`, `dmemREN`, `dmemWEN` are therefore 0.
- Lane counter width is `$clog2(THREADS)`. It never wraps inside an operation, because `DONE` is taken at `THREADS-1`.
- Loaded data registers hold their value until overwritten by a later read. Writes never modify `vdload` or `sdload`.

## Timing
- Request seen in `IDLE` at cycle 0 → `ACCESS` from cycle 1.
- Zero-wait cache:
  - Scalar access: `dHit` at cycle 2.
  - Vector access: `dHit` at cycle `THREADS+1` (cycle 5 for `THREADS = 4`).
- Each cache wait state adds one cycle to the lane being served.
- Outputs `dmem*` are combinational from the state, `lane` and inputs. `dHit` is a Moore output of `DONE`.
- Instruction and data accesses are independent. Cache-side arbitration between them is outside this block.

## Configuration
- `VLSU_COALESCE_EN` defined:
  - Applies in `ACCESS` for a vector read with `lane > 0` and `vdaddr[lane] == vdaddr[lane-1]`.
  - `dmemREN` stays 0 and `vdload[lane]` copies `vdload[lane-1]`.
  - The lane completes in one cycle with no cache access.
  - Writes are never coalesced.
- `VLSU_COALESCE_EN` undefined: every lane issues a cache access.

## Structure
- `cpu_types_pkg` gains `vlsu_state_t` (enum `IDLE`, `ACCESS`, `DONE`).
- One sub-module is natural: `vlsu_lane_seq`. It holds the lane counter, the last-lane compare and, when enabled, the coalesce compare.

## Test plan
- Scalar read: `sdaddr = 0x100`, cache hits immediately with `0xDEADBEEF` → `sdload = 0xDEADBEEF`; `dHit` pulses at cycle 2, once.
- Vector read, `THREADS = 4`:
  - Stimulus: `vdaddr = {0x0, 0x4, 0x8, 0xC}`, zero-wait cache.
  - Response: `dmemaddr` sequence `0x0, 0x4, 0x8, 0xC` on cycles 1–4; `vdload` filled per lane; `dHit` at cycle 5.
- Vector write with 2 wait states on lane 2 → `dmemWEN` high for 6 cycles, `dmemstore` tracks `vdstore[lane]`, `dHit` at cycle 7.
- Reset and abort:
  - `RST` pulse during lane 1 of a vector read → immediate `IDLE`, all `vdload = 0`, `dmemREN = 0`.
  - `halt` during `ACCESS` → no `dHit`.
- `readReq` and `writeReq` both high → write performed; loads unchanged.
- With `VLSU_COALESCE_EN`, `vdaddr = {0x20, 0x20, 0x24, 0x24}` → two cache reads; `vdload[1] = vdload[0]`; `dHit` at cycle 5.
